// File: rtl/uart_wb_host.sv
// Wishbone classic master that configures a 16550-style UART and then polls LSR to move bytes
// between valid/ready streams and THR/RBR. Optional ack timeout: UART_WB_HOST_TIMEOUT_EN.
module uart_wb_host #(
  parameter logic [15:0] DIVISOR     = 16'd27,
  parameter logic [7:0]  LCR_VAL     = 8'h03,
  parameter logic [7:0]  ACK_TIMEOUT = 8'd255
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       init_done_o,
  output logic       err_o,
  output logic [2:0] wbm_adr_o,
  output logic [7:0] wbm_dat_o,
  input  logic [7:0] wbm_dat_i,
  output logic       wbm_we_o,
  output logic       wbm_stb_o,
  output logic       wbm_cyc_o,
  output logic [3:0] wbm_sel_o,
  input  logic       wbm_ack_i
);

  typedef enum logic [3:0] {
    StCfgLcrDlab, StCfgDll, StCfgDlm, StCfgLcr, StCfgFcr, StCfgIer,
    StIdle, StPollLsr, StWrThr, StRdRbr
  } state_e;

  state_e     state_q, state_next;
  logic       cyc_q, we_q, init_done_q, rx_valid_q;
  logic [2:0] adr_q;
  logic [7:0] dat_q, rx_data_q;
  logic       hold_q;
  logic [7:0] hold_data_q;
  logic [2:0] acc_adr;
  logic [7:0] acc_dat;
  logic       acc_we;
  logic       tmo;
  logic       wr_done;

  assign wr_done = (state_q == StWrThr) & cyc_q & wbm_ack_i;

  // Register access issued by each bus state.
  always_comb begin
    acc_adr = 3'd0;
    acc_dat = 8'h00;
    acc_we  = 1'b0;
    case (state_q)
      StCfgLcrDlab: begin acc_adr = 3'd3; acc_dat = LCR_VAL | 8'h80;  acc_we = 1'b1; end
      StCfgDll:     begin acc_adr = 3'd0; acc_dat = DIVISOR[7:0];     acc_we = 1'b1; end
      StCfgDlm:     begin acc_adr = 3'd1; acc_dat = DIVISOR[15:8];    acc_we = 1'b1; end
      StCfgLcr:     begin acc_adr = 3'd3; acc_dat = LCR_VAL & 8'h7F;  acc_we = 1'b1; end
      StCfgFcr:     begin acc_adr = 3'd2; acc_dat = 8'h07;            acc_we = 1'b1; end
      StCfgIer:     begin acc_adr = 3'd1; acc_dat = 8'h00;            acc_we = 1'b1; end
      StPollLsr:    acc_adr = 3'd5;
      StWrThr:      begin acc_adr = 3'd0; acc_dat = hold_data_q;      acc_we = 1'b1; end
      default:      ;
    endcase
  end

  // Successor once the current access ends; a timeout (no ack) still advances config steps.
  always_comb begin
    state_next = StIdle;
    case (state_q)
      StCfgLcrDlab: state_next = StCfgDll;
      StCfgDll:     state_next = StCfgDlm;
      StCfgDlm:     state_next = StCfgLcr;
      StCfgLcr:     state_next = StCfgFcr;
      StCfgFcr:     state_next = StCfgIer;
      StPollLsr: begin
        if (wbm_ack_i) begin
          if (wbm_dat_i[0])                state_next = StRdRbr;
          else if (hold_q && wbm_dat_i[5]) state_next = StWrThr;
        end
      end
      default:      state_next = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= StCfgLcrDlab;
      cyc_q       <= 1'b0;
      adr_q       <= 3'd0;
      dat_q       <= 8'h00;
      we_q        <= 1'b0;
      init_done_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= 8'h00;
    end else begin
      rx_valid_q <= 1'b0;
      if (state_q == StIdle) begin
        state_q <= StPollLsr;
      end else if (!cyc_q) begin
        cyc_q <= 1'b1;
        adr_q <= acc_adr;
        dat_q <= acc_dat;
        we_q  <= acc_we;
      end else if (wbm_ack_i || tmo) begin
        cyc_q   <= 1'b0;
        we_q    <= 1'b0;
        state_q <= state_next;
        if (state_q == StCfgIer) init_done_q <= 1'b1;
        if (state_q == StRdRbr && wbm_ack_i) begin
          rx_valid_q <= 1'b1;
          rx_data_q  <= wbm_dat_i;
        end
      end
    end
  end

  // Single-entry transmit holding register; refill allowed on the THR ack cycle.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      hold_q      <= 1'b0;
      hold_data_q <= 8'h00;
    end else if (tx_valid_i && tx_ready_o) begin
      hold_q      <= 1'b1;
      hold_data_q <= tx_data_i;
    end else if (wr_done) begin
      hold_q <= 1'b0;
    end
  end

`ifdef UART_WB_HOST_TIMEOUT_EN
  logic [7:0] tmo_cnt_q;
  logic       err_q;

  assign tmo = cyc_q & ~wbm_ack_i & (tmo_cnt_q == ACK_TIMEOUT - 8'd1);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      tmo_cnt_q <= 8'd0;
      err_q     <= 1'b0;
    end else begin
      if (cyc_q && !wbm_ack_i && !tmo) tmo_cnt_q <= tmo_cnt_q + 8'd1;
      else                             tmo_cnt_q <= 8'd0;
      if (tmo) err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  logic unused_ack_timeout;
  assign unused_ack_timeout = ^ACK_TIMEOUT;
  assign tmo   = 1'b0;
  assign err_o = 1'b0;
`endif

  assign tx_ready_o  = init_done_q & (~hold_q | wr_done);
  assign rx_data_o   = rx_data_q;
  assign rx_valid_o  = rx_valid_q;
  assign init_done_o = init_done_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;
  assign wbm_we_o    = we_q;
  assign wbm_stb_o   = cyc_q;
  assign wbm_cyc_o   = cyc_q;
  assign wbm_sel_o   = 4'b0001;

endmodule

// File: tb/tb_uart_wb_host.sv
// Randomized bench for uart_wb_host: transaction-level model of the UART host behaviour with a
// behavioural Wishbone slave supplying LSR/RBR values and random ack latency.
module tb_uart_wb_host;

  localparam int KLsr = 0;
  localparam int KRbr = 1;
  localparam int KThr = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       init_done;
  logic       err;
  logic [2:0] adr;
  logic [7:0] dat_out;
  logic [7:0] dat_in = 8'h00;
  logic       we, stb, cyc, ack = 1'b0;
  logic [3:0] sel;

  always #5 clk = ~clk;

  uart_wb_host dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .tx_data_i  (tx_data),
    .tx_valid_i (tx_valid),
    .tx_ready_o (tx_ready),
    .rx_data_o  (rx_data),
    .rx_valid_o (rx_valid),
    .init_done_o(init_done),
    .err_o      (err),
    .wbm_adr_o  (adr),
    .wbm_dat_o  (dat_out),
    .wbm_dat_i  (dat_in),
    .wbm_we_o   (we),
    .wbm_stb_o  (stb),
    .wbm_cyc_o  (cyc),
    .wbm_sel_o  (sel),
    .wbm_ack_i  (ack)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected configuration writes for DIVISOR=27, LCR_VAL=3.
  logic [2:0] cfg_adr [6] = '{3'd3, 3'd0, 3'd1, 3'd3, 3'd2, 3'd1};
  logic [7:0] cfg_dat [6] = '{8'h83, 8'h1B, 8'h00, 8'h03, 8'h07, 8'h00};

  // Model and stimulus state.
  int         cfg_idx = 0;
  int         next_kind = KLsr;
  bit         held = 0;
  logic [7:0] held_byte = 8'h00;
  bit         exp_rx = 0;
  logic [7:0] exp_rx_data = 8'h00;
  bit         cyc_prev = 0, gap_needed = 0, acc_pend = 0;
  logic [2:0] s_adr = 3'd0;
  logic [7:0] s_dat = 8'h00;
  logic       s_we = 1'b0;
  int         wait_cnt = 0, delay = 0, fixed_delay = -1;
  bit         lsr_force = 0;
  logic [7:0] lsr_val = 8'h00, lsr_v;
  bit         tx_en = 0, push_req = 0;
  logic [7:0] push_byte = 8'h00;
  bit         blk_thr = 0, hold_all = 0;
  int         thr_writes = 0;
  logic [7:0] last_thr = 8'h00;
  bit         init_now, held_now, wr_now, exp_ready;

  always @(negedge clk) begin
    if (rst) begin
      cfg_idx = 0; next_kind = KLsr; held = 0; exp_rx = 0;
      cyc_prev = 0; gap_needed = 0; acc_pend = 0;
      ack = 1'b0; tx_valid = 1'b0; dat_in = 8'h00;
    end else begin
      init_now = (cfg_idx == 6);
      held_now = held;
      wr_now   = 0;
      if (acc_pend) begin tx_valid = 1'b0; acc_pend = 0; end
      check_eq("rx_valid", rx_valid, exp_rx);
      if (exp_rx) check_eq("rx_data", rx_data, exp_rx_data);
      exp_rx = 0;
      check_eq("init_done", init_done, init_now);
      check_eq("stb_eq_cyc", stb, cyc);
      check_eq("sel", sel, 4'b0001);
`ifndef UART_WB_HOST_TIMEOUT_EN
      check_eq("err_zero", err, 1'b0);
`endif
      if (gap_needed) check_eq("idle_gap", cyc, 1'b0);
      gap_needed = 0;
      ack = 1'b0;
      dat_in = 8'($urandom);
      if (cyc) begin
        if (!cyc_prev) begin
          s_adr = adr; s_dat = dat_out; s_we = we; wait_cnt = 0;
          delay = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 2));
        end else begin
          check_eq("bus_stable", {adr, dat_out, we}, {s_adr, s_dat, s_we});
        end
        if (wait_cnt >= delay && !hold_all && !(blk_thr && we && adr == 3'd0 && init_now)) begin
          ack = 1'b1;
          gap_needed = 1;
          if (cfg_idx < 6) begin
            check_eq("cfg_adr", adr, cfg_adr[cfg_idx]);
            check_eq("cfg_dat", dat_out, cfg_dat[cfg_idx]);
            check_eq("cfg_we", we, 1'b1);
            cfg_idx++;
          end else begin
            case (next_kind)
              KLsr: begin
                check_eq("lsr_adr", adr, 3'd5);
                check_eq("lsr_we", we, 1'b0);
                if (lsr_force) lsr_v = lsr_val;
                else begin
                  lsr_v = 8'($urandom) & 8'hDE;
                  if ($urandom_range(0, 3) == 0) lsr_v[0] = 1'b1;
                  if ($urandom_range(0, 1) == 0) lsr_v[5] = 1'b1;
                end
                dat_in = lsr_v;
                if (lsr_v[0])                next_kind = KRbr;
                else if (held_now && lsr_v[5]) next_kind = KThr;
                else                         next_kind = KLsr;
              end
              KRbr: begin
                check_eq("rbr_adr", adr, 3'd0);
                check_eq("rbr_we", we, 1'b0);
                exp_rx = 1;
                exp_rx_data = dat_in;
                next_kind = KLsr;
              end
              default: begin
                check_eq("thr_adr", adr, 3'd0);
                check_eq("thr_we", we, 1'b1);
                check_eq("thr_dat", dat_out, held_byte);
                wr_now = 1;
                next_kind = KLsr;
              end
            endcase
          end
          if (we && adr == 3'd0 && init_now) begin
            thr_writes++;
            last_thr = dat_out;
          end
        end else begin
          wait_cnt++;
        end
      end
      cyc_prev = cyc && !ack;
      if (!tx_valid) begin
        if (push_req) begin
          tx_valid = 1'b1; tx_data = push_byte; push_req = 0;
        end else if (tx_en && $urandom_range(0, 3) == 0) begin
          tx_valid = 1'b1; tx_data = 8'($urandom);
        end
      end
      #1;
      exp_ready = init_now && (!held_now || wr_now);
      check_eq("tx_ready", tx_ready, exp_ready);
      held = held_now && !wr_now;
      if (tx_valid && tx_ready) begin
        held = 1; held_byte = tx_data; acc_pend = 1;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int  base, n;
  bit  found;

  initial begin
    #12;
    check_eq("rst_adr", adr, 3'd0);
    check_eq("rst_dat", dat_out, 8'h00);
    check_eq("rst_we", we, 1'b0);
    check_eq("rst_stb", stb, 1'b0);
    check_eq("rst_cyc", cyc, 1'b0);
    check_eq("rst_sel", sel, 4'b0001);
    check_eq("rst_tx_ready", tx_ready, 1'b0);
    check_eq("rst_rx_valid", rx_valid, 1'b0);
    check_eq("rst_rx_data", rx_data, 8'h00);
    check_eq("rst_init_done", init_done, 1'b0);
    check_eq("rst_err", err, 1'b0);

    // Configuration with a slave acking after one wait cycle.
    fixed_delay = 1;
    @(negedge clk); #3 rst = 1'b0;
    for (int i = 0; i < 200 && cfg_idx < 6; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check_eq("init_done_rises", init_done, 1'b1);
    fixed_delay = -1;

    // Random traffic.
    tx_en = 1;
    repeat (3000) @(negedge clk);
    check_eq("thr_seen", thr_writes > 0, 1'b1);

    // LSR stuck without THRE while a byte is held, then THRE appears.
    tx_en = 0;
    for (int i = 0; i < 500 && (held || tx_valid); i++) @(negedge clk);
    lsr_force = 1; lsr_val = 8'h00;
    push_byte = 8'h55; push_req = 1;
    for (int i = 0; i < 50 && !held; i++) @(negedge clk);
    base = thr_writes;
    repeat (150) @(negedge clk);
    check_eq("stuck_no_thr", thr_writes - base, 0);
    check_eq("stuck_tx_ready", tx_ready, 1'b0);
    lsr_val = 8'h20;
    for (int i = 0; i < 50 && thr_writes == base; i++) @(negedge clk);
    check_eq("thre_write_cnt", thr_writes - base, 1);
    check_eq("thre_write_dat", last_thr, 8'h55);
    lsr_force = 0;

    // Reset while a THR write is in flight.
    tx_en = 1; blk_thr = 1; found = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (cyc && we && adr == 3'd0 && init_done) begin found = 1; break; end
    end
    check_eq("thr_inflight_found", found, 1'b1);
    tx_en = 0;
    #3 rst = 1'b1;
    blk_thr = 0;
    #1;
    check_eq("rst_mid_cyc", cyc, 1'b0);
    check_eq("rst_mid_stb", stb, 1'b0);
    check_eq("rst_mid_init", init_done, 1'b0);
    @(negedge clk); #3 rst = 1'b0;
    base = thr_writes;
    repeat (300) @(negedge clk);
    check_eq("held_byte_discarded", thr_writes - base, 0);
    check_eq("reconfig_done", init_done, 1'b1);
    tx_en = 1;
    repeat (1000) @(negedge clk);

    // Ack withheld.
    tx_en = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #3;
      if (gap_needed) break;
    end
    hold_all = 1;
    for (int i = 0; i < 20 && cyc; i++) @(negedge clk);
    for (int i = 0; i < 20 && !cyc; i++) @(negedge clk);
    n = 1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!cyc) break;
      n++;
    end
`ifdef UART_WB_HOST_TIMEOUT_EN
    check_eq("timeout_cycles", n, 255);
    check_eq("timeout_err", err, 1'b1);
    repeat (20) @(negedge clk);
    check_eq("timeout_err_sticky", err, 1'b1);
`else
    check_eq("no_timeout_cycles", n, 401);
    check_eq("no_timeout_cyc", cyc, 1'b1);
    check_eq("no_timeout_err", err, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
